// File: rtl/vga_sync_gen.sv
// Raster timing generator: divides clk to a pixel enable and runs the x/y counters,
// producing active-low syncs and a visible-area window aligned with the coordinates.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt, div_cnt_d;
    logic             p_tick_d;
    logic [9:0]       x_d, y_d;
    logic             h_wrap, v_wrap;

    always_comb begin
        div_cnt_d = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        // p_tick is registered, so it must anticipate the divider reaching its last count
        p_tick_d  = (div_cnt_d == DIV_LAST);
        h_wrap    = (x == H_LAST);
        v_wrap    = (y == V_LAST);
        x_d       = h_wrap ? 10'd0 : x + 10'd1;
        y_d       = y;
        if (h_wrap) begin
            y_d = v_wrap ? 10'd0 : y + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            p_tick     <= 1'b0;
            x          <= 10'd0;
            y          <= 10'd0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_d;
            p_tick     <= p_tick_d;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
            // Syncs and window come from the next counter values so they stay aligned with x/y
            if (p_tick) begin
                x          <= x_d;
                y          <= y_d;
                hsync      <= !((x_d >= HS_START) && (x_d < HS_END));
                vsync      <= !((y_d >= VS_START) && (y_d < VS_END));
                video_on   <= (x_d < H_VIS) && (y_d < V_VIS);
                line_tick  <= h_wrap;
                frame_tick <= h_wrap && v_wrap;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a full-size instance for reset/line timing and a shrunken raster
// instance so frame, vsync and wrap behaviour fit in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       pt_f, hs_f, vs_f, vo_f, lt_f, ft_f;
    logic [9:0] x_f, y_f;
    logic       pt_s, hs_s, vs_s, vo_s, lt_s, ft_s;
    logic [9:0] x_s, y_s;

    vga_sync_gen dut_f (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_tick     (pt_f),
        .hsync      (hs_f),
        .vsync      (vs_f),
        .video_on   (vo_f),
        .x          (x_f),
        .y          (y_f),
        .line_tick  (lt_f),
        .frame_tick (ft_f)
    );

    // Small raster: H_TOTAL 32 (hsync 23..27), V_TOTAL 17 (vsync 12..14), frame 2176 clk
    vga_sync_gen #(
        .CLK_DIV   (4),
        .H_DISPLAY (20),
        .H_FRONT   (3),
        .H_SYNC    (5),
        .H_BACK    (4),
        .V_DISPLAY (10),
        .V_FRONT   (2),
        .V_SYNC    (3),
        .V_BACK    (2)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_tick     (pt_s),
        .hsync      (hs_s),
        .vsync      (vs_s),
        .video_on   (vo_s),
        .x          (x_s),
        .y          (y_s),
        .line_tick  (lt_s),
        .frame_tick (ft_s)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit oor      = 1'b0;
    bit dbl      = 1'b0;
    bit lt_pf = 1'b0, ft_pf = 1'b0, lt_ps = 1'b0, ft_ps = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            lt_pf <= 1'b0; ft_pf <= 1'b0; lt_ps <= 1'b0; ft_ps <= 1'b0;
        end else begin
            if (x_f >= 10'd800 || y_f >= 10'd525 || x_s >= 10'd32 || y_s >= 10'd17) oor <= 1'b1;
            if ((lt_f && lt_pf) || (ft_f && ft_pf) || (lt_s && lt_ps) || (ft_s && ft_ps))
                dbl <= 1'b1;
            lt_pf <= lt_f; ft_pf <= ft_f; lt_ps <= lt_s; ft_ps <= ft_s;
        end
    end

    // Entered at a negedge with rst_n low; releases reset and checks the start-up sequence
    task automatic reset_release_seq(input string pfx);
        int e;
        int first_hi;
        int second_hi;
        check({pfx, "_rst_x"}, int'(x_f), 0);
        check({pfx, "_rst_y"}, int'(y_f), 0);
        check({pfx, "_rst_ptick"}, int'(pt_f), 0);
        check({pfx, "_rst_hsync"}, int'(hs_f), 1);
        check({pfx, "_rst_vsync"}, int'(vs_f), 1);
        check({pfx, "_rst_video_on"}, int'(vo_f), 0);
        check({pfx, "_rst_line_tick"}, int'(lt_f), 0);
        check({pfx, "_rst_frame_tick"}, int'(ft_f), 0);
        check({pfx, "_rst_small_x"}, int'(x_s), 0);
        check({pfx, "_rst_small_hsync"}, int'(hs_s), 1);
        rst_n = 1'b1;
        e = 0;
        first_hi = -1;
        while (first_hi < 0 && e < 16) begin
            tick(); e++;
            if (pt_f) first_hi = e;
        end
        check({pfx, "_first_ptick_cycle"}, first_hi, 3);
        check({pfx, "_x_before_adv"}, int'(x_f), 0);
        tick(); e++;
        check({pfx, "_x_adv1"}, int'(x_f), 1);
        check({pfx, "_y_adv1"}, int'(y_f), 0);
        check({pfx, "_video_on_adv1"}, int'(vo_f), 1);
        check({pfx, "_ptick_low_adv1"}, int'(pt_f), 0);
        check({pfx, "_small_x_adv1"}, int'(x_s), 1);
        second_hi = -1;
        while (second_hi < 0 && e < 32) begin
            tick(); e++;
            if (pt_f) second_hi = e;
        end
        check({pfx, "_ptick_period"}, second_hi - first_hi, 4);
        check({pfx, "_x_hold"}, int'(x_f), 1);
        tick();
        check({pfx, "_x_adv2"}, int'(x_f), 2);
    endtask

    task automatic wait_small_xy(input int wx, input int wy, input string tag);
        int k;
        k = 0;
        while (!(int'(x_s) == wx && int'(y_s) == wy) && k < 5000) begin
            tick(); k++;
        end
        check({tag, "_reach"}, int'(int'(x_s) == wx && int'(y_s) == wy), 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int t0;
        int t1;
        rst_n = 1'b0;
        repeat (3) tick();
        reset_release_seq("rr1");

        // Full-size line period and hsync window
        k = 0;
        while (!lt_f && k < 4000) begin tick(); k++; end
        check("line1_found", int'(lt_f), 1);
        t0 = cyc;
        tick();
        k = 0;
        while (!lt_f && k < 4000) begin tick(); k++; end
        check("line_period", cyc - t0, 3200);
        check("line_tick_x", int'(x_f), 0);
        k = 0;
        while (hs_f && k < 4000) begin tick(); k++; end
        check("hs_start_x", int'(x_f), 656);
        t0 = cyc;
        k = 0;
        while (!hs_f && k < 1000) begin tick(); k++; end
        check("hs_low_clk", cyc - t0, 384);
        check("hs_end_x", int'(x_f), 752);

        // Small raster: frame period, vsync window, wrap
        k = 0;
        while (!ft_s && k < 3000) begin tick(); k++; end
        check("frame1_found", int'(ft_s), 1);
        check("frame1_x", int'(x_s), 0);
        check("frame1_y", int'(y_s), 0);
        check("frame1_line_tick", int'(lt_s), 1);
        t0 = cyc;
        tick();
        check("frame_tick_one_clk", int'(ft_s), 0);
        k = 0;
        while (vs_s && k < 3000) begin tick(); k++; end
        check("vs_start_y", int'(y_s), 12);
        check("vs_start_x", int'(x_s), 0);
        t1 = cyc;
        k = 0;
        while (!vs_s && k < 1000) begin tick(); k++; end
        check("vs_low_clk", cyc - t1, 384);
        check("vs_end_y", int'(y_s), 15);
        k = 0;
        while (!ft_s && k < 3000) begin tick(); k++; end
        check("frame_period", cyc - t0, 2176);
        check("frame2_video_on", int'(vo_s), 1);

        wait_small_xy(19, 9, "vis_last");
        check("vis_last_video_on", int'(vo_s), 1);
        wait_small_xy(20, 9, "vis_right");
        check("vis_right_video_on", int'(vo_s), 0);
        wait_small_xy(0, 10, "vis_below");
        check("vis_below_video_on", int'(vo_s), 0);

        wait_small_xy(31, 16, "wrap");
        k = 0;
        while (x_s == 10'd31 && k < 8) begin tick(); k++; end
        check("wrap_x", int'(x_s), 0);
        check("wrap_y", int'(y_s), 0);
        check("wrap_line_tick", int'(lt_s), 1);
        check("wrap_frame_tick", int'(ft_s), 1);
        tick();
        check("wrap_line_tick_drop", int'(lt_s), 0);
        check("wrap_frame_tick_drop", int'(ft_s), 0);

        // Asynchronous reset mid-hsync
        wait_small_xy(25, 7, "midrst");
        tick();
        check("midrst_pre_hsync", int'(hs_s), 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hsync", int'(hs_s), 1);
        check("midrst_x", int'(x_s), 0);
        check("midrst_y", int'(y_s), 0);
        check("midrst_video_on", int'(vo_s), 0);
        check("midrst_full_x", int'(x_f), 0);
        repeat (3) tick();
        reset_release_seq("rr2");

        check("counter_range", int'(oor), 0);
        check("tick_single_clk", int'(dbl), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
